// File: rtl/decoder_scan_n_pkg.sv
// Shared definitions for decoder_scan_n: mode encodings, FSM states and a
// small helper that says which states drive a live output.
package decoder_scan_n_pkg;

    localparam logic [1:0] MODE_DIRECT = 2'b00;
    localparam logic [1:0] MODE_SCAN   = 2'b01;
    localparam logic [1:0] MODE_SWEEP  = 2'b10;
    localparam logic [1:0] MODE_RSVD   = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DIRECT,
        ST_SCAN,
        ST_SWEEP,
        ST_DONE
    } state_t;

    // True for the states in which one output line is pulled low.
    function automatic logic drives_outputs(input state_t s);
        return (s == ST_DIRECT) || (s == ST_SCAN) || (s == ST_SWEEP);
    endfunction

endpackage

// File: rtl/decoder_scan_n_dec.sv
// Combinational SEL_W-to-2^SEL_W active-low one-hot decoder with enable.
// With en_i low every output is high.
module onehot_dec_n #(
    parameter int unsigned SEL_W = 3
) (
    input  logic [SEL_W-1:0]      sel_i,
    input  logic                  en_i,
    output logic [(1<<SEL_W)-1:0] y_n_o
);

    localparam int unsigned NUM_OUT = 1 << SEL_W;

    // Pull exactly the selected line low when enabled.
    always_comb begin
        y_n_o = '1;
        for (int unsigned i = 0; i < NUM_OUT; i++) begin
            if (en_i && (sel_i == SEL_W'(i))) begin
                y_n_o[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/decoder_scan_n.sv
// Registered SEL_W-to-2^SEL_W active-low decoder with 74138-style enables,
// a DIRECT mode, a free-running SCAN strobe and a one-shot SWEEP with a
// start/busy/done handshake.
module decoder_scan_n
    import decoder_scan_n_pkg::*;
#(
    parameter int unsigned SEL_W    = 3,
    parameter int unsigned TICK_DIV = 4,
    parameter int unsigned DIV_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  g1,
    input  logic                  g2a_n,
    input  logic                  g2b_n,
    input  logic [1:0]            mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic [SEL_W-1:0]      last,
    input  logic                  start,
    output logic [(1<<SEL_W)-1:0] y,
    output logic [SEL_W-1:0]      idx,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned NUM_OUT = 1 << SEL_W;
    localparam logic [DIV_W-1:0] TICK_LAST = DIV_W'(TICK_DIV - 1);

    if (TICK_DIV < 1) begin : g_bad_tick_div
        $error("decoder_scan_n: TICK_DIV must be at least 1");
    end
    if (64'(TICK_DIV) > (64'd1 << DIV_W)) begin : g_bad_div_w
        $error("decoder_scan_n: TICK_DIV-1 does not fit in DIV_W bits");
    end

    state_t               state_q, state_d;
    logic [SEL_W-1:0]     idx_q,   idx_d;
    logic [DIV_W-1:0]     pre_q,   pre_d;
    logic                 busy_q,  busy_d;
    logic                 done_q,  done_d;
    logic [NUM_OUT-1:0]   y_q,     y_d;

    logic en;
    logic tick;
    logic at_end;

    assign en     = g1 & ~g2a_n & ~g2b_n;
    assign tick   = (pre_q == TICK_LAST);
    // >= rather than == so a lowered 'last' still wraps/terminates cleanly.
    assign at_end = (idx_q >= last);

    // Next-state logic; with the enables off everything except y holds.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pre_d   = pre_q;
        busy_d  = busy_q;
        done_d  = done_q;
        if (en) begin
            case (state_q)
                ST_IDLE: begin
                    case (mode)
                        MODE_DIRECT: begin
                            state_d = ST_DIRECT;
                            idx_d   = sel;
                        end
                        MODE_SCAN: begin
                            state_d = ST_SCAN;
                            idx_d   = '0;
                            pre_d   = '0;
                        end
                        MODE_SWEEP: begin
                            if (start) begin
                                state_d = ST_SWEEP;
                                idx_d   = '0;
                                pre_d   = '0;
                                busy_d  = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
                ST_DIRECT, ST_SCAN, ST_SWEEP: begin
                    if ((state_q == ST_DIRECT && mode != MODE_DIRECT) ||
                        (state_q == ST_SCAN   && mode != MODE_SCAN)   ||
                        (state_q == ST_SWEEP  && mode != MODE_SWEEP)) begin
                        // Mode changed under us: abort quietly back to IDLE.
                        state_d = ST_IDLE;
                        idx_d   = '0;
                        pre_d   = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b0;
                    end else if (state_q == ST_DIRECT) begin
                        idx_d = sel;
                    end else if (!tick) begin
                        pre_d = pre_q + 1'b1;
                    end else begin
                        pre_d = '0;
                        if (!at_end) begin
                            idx_d = idx_q + 1'b1;
                        end else if (state_q == ST_SCAN) begin
                            idx_d = '0;
                        end else begin
                            state_d = ST_DONE;
                            idx_d   = '0;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                    done_d  = 1'b0;
                end
                default: begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    pre_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                end
            endcase
        end
    end

    // Decode the next index so y lands in the same edge as idx.
    onehot_dec_n #(
        .SEL_W(SEL_W)
    ) u_dec (
        .sel_i (idx_d),
        .en_i  (en && drives_outputs(state_d)),
        .y_n_o (y_d)
    );

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            pre_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            y_q     <= '1;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pre_q   <= pre_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            y_q     <= y_d;
        end
    end

    assign y    = y_q;
    assign idx  = idx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_decoder_scan_n.sv
// Self-checking bench for decoder_scan_n (SEL_W = 3, TICK_DIV = 4): directed
// scenarios followed by randomized stimulus against a behavioural model.
module tb_decoder_scan_n;
    import decoder_scan_n_pkg::*;

    localparam int unsigned SEL_W = 3;
    localparam int unsigned TD    = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       g1, g2a_n, g2b_n;
    logic [1:0] mode;
    logic [2:0] sel, last;
    logic       start;
    logic [7:0] y;
    logic [2:0] idx;
    logic       busy, done;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    decoder_scan_n #(
        .SEL_W   (SEL_W),
        .TICK_DIV(TD),
        .DIV_W   (16)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .g1   (g1),
        .g2a_n(g2a_n),
        .g2b_n(g2b_n),
        .mode (mode),
        .sel  (sel),
        .last (last),
        .start(start),
        .y    (y),
        .idx  (idx),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Behavioural model: what the block is doing, which position it shows,
    // and how many cycles that position has been shown.
    typedef enum int {A_IDLE, A_DIRECT, A_SCAN, A_SWEEP, A_DONE} act_e;
    act_e m_act;
    int   m_pos;
    int   m_dwell;
    bit   m_busy, m_done, m_lit;

    task automatic model_reset();
        m_act = A_IDLE; m_pos = 0; m_dwell = 1;
        m_busy = 0; m_done = 0; m_lit = 0;
    endtask

    task automatic model_abort();
        m_act = A_IDLE; m_pos = 0; m_dwell = 1; m_busy = 0; m_done = 0;
    endtask

    task automatic model_edge();
        bit enabled;
        enabled = g1 && !g2a_n && !g2b_n;
        if (!enabled) begin
            m_lit = 0;
            return;
        end
        case (m_act)
            A_IDLE: begin
                if (mode == MODE_DIRECT) begin
                    m_act = A_DIRECT; m_pos = int'(sel);
                end else if (mode == MODE_SCAN) begin
                    m_act = A_SCAN; m_pos = 0; m_dwell = 1;
                end else if (mode == MODE_SWEEP && start) begin
                    m_act = A_SWEEP; m_pos = 0; m_dwell = 1; m_busy = 1;
                end
            end
            A_DIRECT: if (mode != MODE_DIRECT) model_abort(); else m_pos = int'(sel);
            A_SCAN: begin
                if (mode != MODE_SCAN) model_abort();
                else if (m_dwell < int'(TD)) m_dwell++;
                else begin
                    m_dwell = 1;
                    m_pos = (m_pos >= int'(last)) ? 0 : m_pos + 1;
                end
            end
            A_SWEEP: begin
                if (mode != MODE_SWEEP) model_abort();
                else if (m_dwell < int'(TD)) m_dwell++;
                else if (m_pos >= int'(last)) begin
                    m_act = A_DONE; m_pos = 0; m_dwell = 1; m_busy = 0; m_done = 1;
                end else begin
                    m_dwell = 1; m_pos = m_pos + 1;
                end
            end
            default: begin
                m_act = A_IDLE; m_done = 0;
            end
        endcase
        m_lit = (m_act == A_DIRECT) || (m_act == A_SCAN) || (m_act == A_SWEEP);
    endtask

    function automatic logic [7:0] exp_y();
        logic [7:0] one;
        one = 8'd1;
        return m_lit ? ~(one << m_pos) : 8'hFF;
    endfunction

    task automatic compare(input string tag);
        chk({tag, ".y"},    32'(y),    32'(exp_y()));
        chk({tag, ".idx"},  32'(idx),  32'(m_pos));
        chk({tag, ".busy"}, 32'(busy), 32'(m_busy));
        chk({tag, ".done"}, 32'(done), 32'(m_done));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        compare(tag);
    endtask

    // Assert reset between edges, check its immediate effect, then release.
    task automatic async_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        chk({tag, ".rst_y"},    32'(y),    32'hFF);
        chk({tag, ".rst_idx"},  32'(idx),  32'h0);
        chk({tag, ".rst_busy"}, 32'(busy), 32'h0);
        chk({tag, ".rst_done"}, 32'(done), 32'h0);
        model_reset();
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int unsigned busy_cnt, done_cnt;
        logic [7:0] y_at_done;
        logic [7:0] pat;

        rst = 1'b1; g1 = 1'b1; g2a_n = 1'b0; g2b_n = 1'b0;
        mode = MODE_DIRECT; sel = 3'd0; last = 3'd0; start = 1'b0;
        model_reset();
        #1;
        chk("reset.y",    32'(y),    32'hFF);
        chk("reset.busy", 32'(busy), 32'h0);
        chk("reset.idx",  32'(idx),  32'h0);
        #6;
        rst = 1'b0;

        // 1. Each enable deasserted on its own blocks every output.
        for (int k = 0; k < 3; k++) begin
            g1 = (k != 0); g2a_n = (k == 1); g2b_n = (k == 2);
            for (int c = 0; c < 3; c++) begin
                mode = 2'($urandom_range(0, 3));
                sel  = 3'($urandom_range(0, 7));
                step("enables");
                chk("enables.y_off", 32'(y), 32'hFF);
            end
        end
        g1 = 1'b1; g2a_n = 1'b0; g2b_n = 1'b0; mode = MODE_DIRECT;

        // 2. DIRECT mode.
        sel = 3'd0; step("direct0"); chk("direct0.y_const", 32'(y), 32'hFE);
        sel = 3'd5; step("direct5"); chk("direct5.y_const", 32'(y), 32'hDF);
        chk("direct5.idx_const", 32'(idx), 32'd5);
        sel = 3'd7; step("direct7"); chk("direct7.y_const", 32'(y), 32'h7F);

        // 3. SCAN over 0..2.
        mode = MODE_SCAN; last = 3'd2;
        step("scan_leave_direct");
        chk("scan_leave_direct.y_const", 32'(y), 32'hFF);
        for (int k = 0; k < 13; k++) begin
            step("scan");
            pat = (k < 12) ? ~(8'd1 << (k / 4)) : 8'hFE;
            chk("scan.y_const", 32'(y), 32'(pat));
            chk("scan.done_const", 32'(done), 32'h0);
        end

        // 4. Full SWEEP with a stray start mid-run.
        mode = MODE_SWEEP; last = 3'd7;
        step("sweep_leave_scan");
        start = 1'b1;
        busy_cnt = 0; done_cnt = 0; y_at_done = 8'h00;
        for (int k = 0; k < 40; k++) begin
            step("sweep");
            if (k == 0) start = 1'b0;
            if (k == 10) start = 1'b1;
            if (k == 12) start = 1'b0;
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                y_at_done = y;
            end
        end
        chk("sweep.busy_cycles", 32'(busy_cnt), 32'd32);
        chk("sweep.done_cycles", 32'(done_cnt), 32'd1);
        chk("sweep.y_at_done",   32'(y_at_done), 32'hFF);

        // 5. SCAN freeze at idx = 1 with the prescaler at 2.
        mode = MODE_SCAN; last = 3'd7;
        for (int k = 0; k < 7; k++) step("freeze_setup");
        chk("freeze_setup.idx_const", 32'(idx), 32'd1);
        g1 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step("freeze");
            chk("freeze.y_const",   32'(y),   32'hFF);
            chk("freeze.idx_const", 32'(idx), 32'd1);
        end
        g1 = 1'b1;
        step("thaw1"); chk("thaw1.idx_const", 32'(idx), 32'd1);
        step("thaw2"); chk("thaw2.idx_const", 32'(idx), 32'd2);

        // 6. Async reset mid-SWEEP, then SCAN -> DIRECT via IDLE.
        mode = MODE_SWEEP; last = 3'd7;
        step("sweep2_leave_scan");
        start = 1'b1; step("sweep2_start"); start = 1'b0;
        for (int k = 0; k < 5; k++) step("sweep2");
        async_reset("sweep2");
        mode = MODE_SCAN; last = 3'd3;
        for (int k = 0; k < 6; k++) step("scan2");
        mode = MODE_DIRECT; sel = 3'd3;
        step("scan2_exit"); chk("scan2_exit.y_const", 32'(y), 32'hFF);
        step("direct3");    chk("direct3.y_const",    32'(y), 32'hF7);
        sel = 3'd6;
        step("direct6");    chk("direct6.y_const",    32'(y), 32'hBF);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            g1    = ($urandom_range(0, 19) != 0);
            g2a_n = ($urandom_range(0, 29) == 0);
            g2b_n = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 29) == 0) last = 3'($urandom_range(0, 7));
            sel   = 3'($urandom_range(0, 7));
            start = ($urandom_range(0, 3) == 0);
            step("rand");
            if ($urandom_range(0, 499) == 0) async_reset("rand");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
